mem_ctl: RTL
============

// Module: mem_ctl
// PURPOSE
//  Data-memory access controller directly downstream of the instruction decoder.
//  Turns the decoder's single-cycle ram_read/ram_write strobes into a req/ack bus transaction.
//  Returns mem_busy/mem_ready, which the decoder uses to stall load/store instructions.
//  Loads are blocking and end with a one-cycle mem_ready carrying read data for the reg-in mux.
//  Stores are posted: address and data are latched and the pipeline continues.
// PARAMETERS
//  ADDR_W    16    address width (ALU result)
//  DATA_W    16    data width
//  TIMEOUT   255   max cycles waiting for bus_ack; 0 disables the timeout
//  ERR_DATA  16'hFFFF  read data returned on a timed-out load
// PORTS
//  clk        in   1       system clock, all state on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  ram_read   in   1       decoder load strobe
//  ram_write  in   1       decoder store strobe
//  addr       in   ADDR_W  ALU output (effective address)
//  wdata      in   DATA_W  store data (reg_r bus)
//  mem_busy   out  1       transaction in flight, to decoder
//  mem_ready  out  1       load data valid this cycle, to decoder
//  mem_rdata  out  DATA_W  load result, to reg-in mux
//  bus_req    out  1       bus request
//  bus_we     out  1       1 = write, 0 = read
//  bus_addr   out  ADDR_W  bus address
//  bus_wdata  out  DATA_W  bus write data
//  bus_rdata  in   DATA_W  bus read data, valid with bus_ack
//  bus_ack    in   1       transfer complete; sampled only while bus_req=1
//  bus_err    out  1       sticky timeout flag
//  err_clr    in   1       clears bus_err
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - State goes to IDLE.
//   - All outputs are 0: mem_busy, mem_ready, mem_rdata, bus_req, bus_we, bus_addr, bus_wdata, bus_err.
//   - An in-flight bus_req drops immediately; the transaction is abandoned.
//  FSM states: IDLE, BUSY, READY. Outputs are decoded from registered state:
//   - mem_busy  = (state==BUSY)
//   - mem_ready = (state==READY)
//   - bus_req   = (state==BUSY)
//  IDLE:
//   - ram_write=1: latch addr/wdata, bus_we=1, go BUSY.
//   - Else ram_read=1: latch addr, bus_we=0, go BUSY.
//   - Write wins if both strobes are high; the read is dropped.
//  BUSY:
//   - bus_addr, bus_we and bus_wdata are held stable.
//   - Strobes are ignored; the decoder stalls on mem_busy.
//   - Timeout counter increments each BUSY cycle and clears on entry to BUSY.
//   - bus_ack=1, read: mem_rdata<=bus_rdata, go READY.
//   - bus_ack=1, write: go IDLE. Writes produce no mem_ready.
//   - TIMEOUT!=0 and count reaches TIMEOUT-1 without ack: bus_err<=1, then
//     read: mem_rdata<=ERR_DATA, go READY; write: go IDLE.
//  READY:
//   - Lasts exactly one cycle, then IDLE.
//   - mem_rdata holds its value until the next load completes.
//   - Strobes in READY are ignored; the decoder issues none there.
//  Latency, strobe at edge 0:
//   - bus_req is high from cycle 1; the earliest ack is in cycle 1.
//   - Load: mem_ready in cycle ack+1. Zero-wait load = 3 cycles strobe-to-writeback.
//   - Store: IDLE again the cycle after ack; back-to-back stores stall one cycle minimum.
//  bus_err is sticky and set by timeout only. err_clr clears it; a set in the same cycle wins.
//  Late ack: a bus_ack arriving while bus_req=0 is ignored.
// TESTING
//  - Load, zero wait: ram_read, addr=16'h0040, ack in cycle 1 with rdata=16'hBEEF
//    -> busy in cycle 1 only, mem_ready + rdata BEEF in cycle 2, idle in cycle 3.
//  - Store, 3 wait states: ram_write, addr=16'h0100, wdata=16'h1234
//    -> bus_req/bus_we high for 4 cycles with stable addr/data; no mem_ready; busy low after ack.
//  - Store then immediate load: load strobe held during busy
//    -> no second request until the write acks; then the read issues and mem_ready follows.
//  - Timeout, TIMEOUT=4, load, never ack
//    -> bus_req high 4 cycles then low; bus_err=1; mem_ready with rdata FFFF; err_clr -> bus_err=0.
//  - Both strobes high, addr=16'h0008 -> single write transaction, no read, no mem_ready.
//  - rst_n low mid-BUSY -> bus_req/mem_busy low asynchronously; after release an ack is ignored and state is IDLE.

Source files
------------

// File: rtl/mem_ctl.sv
// mem_ctl: turns decoder load/store strobes into a req/ack bus transaction.
// Loads block and end in a one-cycle mem_ready; stores are posted.
module mem_ctl #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ram_read,
    input  logic              ram_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              mem_busy,
    output logic              mem_ready,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              bus_err,
    input  logic              err_clr
);
    typedef enum logic [1:0] {IDLE, BUSY, READY} state_t;

    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          start, expire, done;

    assign start     = (state == IDLE) && (ram_read || ram_write);
    // an ack in the final allowed cycle still completes normally
    assign expire    = (state == BUSY) && !bus_ack && (TIMEOUT != 0) && (cnt == LAST);
    assign done      = (state == BUSY) && (bus_ack || expire);
    assign mem_busy  = (state == BUSY);
    assign bus_req   = (state == BUSY);
    assign mem_ready = (state == READY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? BUSY : IDLE;
            BUSY:    state_nx = done ? (bus_we ? IDLE : READY) : BUSY;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            mem_rdata <= '0;
            bus_err   <= 1'b0;
        end else begin
            cnt     <= (state == BUSY) ? cnt + 1'b1 : '0;
            bus_err <= expire | (bus_err & ~err_clr);
            if (start) begin
                bus_addr <= addr;
                bus_we   <= ram_write;
                if (ram_write) bus_wdata <= wdata;
            end
            if (done && !bus_we) mem_rdata <= bus_ack ? bus_rdata : ERR_DATA;
        end
    end
endmodule
